// File: rtl/timer_24_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timer_24_ctrl_pkg
//   Constants shared by the timer family: default count and prescaler widths
//   and the control FSM state encoding.
// -----------------------------------------------------------------------------
package timer_24_ctrl_pkg;

  localparam int unsigned TIMER_DEF_W  = 24;
  localparam int unsigned TIMER_DEF_PW = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

endpackage

// File: rtl/timer_24_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
//   Clock divider. While enabled it counts clocks and raises step_o on every
//   (div_i+1)-th enabled clock. Disabling freezes the phase; clear restarts it.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   en_i        - count enable (frozen when low)
//   clr_i       - synchronous phase clear, overrides enable
//   div_i       - divide setting (step every div_i+1 enabled clocks)
//   step_o      - combinational step strobe for the current cycle
// -----------------------------------------------------------------------------
module timer_prescaler
  import timer_24_ctrl_pkg::*;
#(
  parameter int unsigned PW = TIMER_DEF_PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [PW-1:0] div_i,
  output logic          step_o
);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    step_o = en_i && !clr_i && (cnt_q == div_i);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (step_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_24_ctrl.sv
// -----------------------------------------------------------------------------
// timer_24_ctrl
//   Prescaled compare-and-reload timer with one-shot/periodic modes, hold,
//   abort and a sticky terminal-count interrupt.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   start, stop   - one-cycle run request / abort request
//   hold          - level; freezes count and prescaler phase while high
//   cfg_period    - terminal count (latched at start)
//   cfg_prescale  - divider setting (latched at start)
//   cfg_oneshot   - 1: stop in DONE after terminal count, 0: reload (latched)
//   irq_clr       - clears the sticky interrupt
//   count         - current count
//   step          - registered pulse on each count advance
//   tick          - registered pulse when count returns to 0 at terminal count
//   irq           - sticky terminal-count flag
//   busy, done    - RUN/PAUSE and DONE status
// -----------------------------------------------------------------------------
module timer_24_ctrl
  import timer_24_ctrl_pkg::*;
#(
  parameter int unsigned W  = TIMER_DEF_W,
  parameter int unsigned PW = TIMER_DEF_PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          hold,
  input  logic [W-1:0]  cfg_period,
  input  logic [PW-1:0] cfg_prescale,
  input  logic          cfg_oneshot,
  input  logic          irq_clr,
  output logic [W-1:0]  count,
  output logic          step,
  output logic          tick,
  output logic          irq,
  output logic          busy,
  output logic          done
);

  timer_state_e  state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  period_q, period_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          oneshot_q, oneshot_d;
  logic          step_q, step_d;
  logic          tick_q, tick_d;
  logic          irq_q, irq_d;

  logic active, start_ok, pre_en, pre_clr, adv, wrap;

  // Counting is enabled in PAUSE as well as RUN whenever hold is low, so the
  // cycle on which hold drops already advances the prescaler; PAUSE is simply
  // the "hold seen high" state.
  always_comb begin
    active   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    start_ok = start && !stop && !active;
    pre_en   = active && !hold && !stop;
    pre_clr  = stop || start_ok;
  end

  timer_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en_i   (pre_en),
    .clr_i  (pre_clr),
    .div_i  (presc_q),
    .step_o (adv)
  );

  always_comb begin
    wrap = adv && (count_q == period_q);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN, ST_PAUSE: begin
          if (hold)                  state_d = ST_PAUSE;
          else if (wrap && oneshot_q) state_d = ST_DONE;
          else                        state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    done = (state_q == ST_DONE);
  end

  // Datapath next values
  always_comb begin
    count_d   = count_q;
    period_d  = period_q;
    presc_d   = presc_q;
    oneshot_d = oneshot_q;
    if (stop || start_ok) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (adv) begin
      count_d = count_q + 1'b1;
    end
    if (start_ok) begin
      period_d  = cfg_period;
      presc_d   = cfg_prescale;
      oneshot_d = cfg_oneshot;
    end
    step_d = adv;
    tick_d = wrap;
    // Set wins over a coincident clear.
    irq_d  = wrap || (irq_q && !irq_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      period_q  <= '0;
      presc_q   <= '0;
      oneshot_q <= 1'b0;
      step_q    <= 1'b0;
      tick_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      period_q  <= period_d;
      presc_q   <= presc_d;
      oneshot_q <= oneshot_d;
      step_q    <= step_d;
      tick_q    <= tick_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    count = count_q;
    step  = step_q;
    tick  = tick_q;
    irq   = irq_q;
  end

endmodule
